// File: rtl/fwd_sel_gen.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_gen
// Brief    : Forwarding-select generator for the 5-stage RV32I pipeline.
//            Keeps a shadow copy of rd / reg_write / mem_read for the EX,
//            MEM and WB instructions, registers the EX operand selects and
//            raises a combinational load-use stall.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel_gen (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] id_rd_i,
    input  logic       id_reg_write_i,
    input  logic       id_mem_read_i,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic [1:0] fwd_a_sel_o,
    output logic [1:0] fwd_b_sel_o,
    output logic       stall_o
);

    localparam logic [1:0] C_SEL_RF  = 2'd0;
    localparam logic [1:0] C_SEL_MEM = 2'd1;
    localparam logic [1:0] C_SEL_WB  = 2'd2;
    localparam logic [1:0] C_SEL_RET = 2'd3;
    localparam logic [4:0] C_X0      = 5'd0;

    // Shadow stages: S1 = EX, S2 = MEM, S3 = WB
    logic       r_s1_valid, r_s2_valid, r_s3_valid;
    logic [4:0] r_s1_rd,    r_s2_rd,    r_s3_rd;
    logic       r_s1_rw,    r_s2_rw,    r_s3_rw;
    logic       r_s1_mr,    r_s2_mr,    r_s3_mr;
    logic [1:0] r_fwd_a_sel, r_fwd_b_sel;

    logic       w_s1_src, w_s2_src, w_s3_src;
    logic       w_a_m1, w_a_m2, w_a_m3;
    logic       w_b_m1, w_b_m2, w_b_m3;
    logic       w_a_use, w_b_use;
    logic [1:0] w_sel_a, w_sel_b;
    logic       w_stall;

    // A stage can forward only if it will really write a non-x0 register
    assign w_s1_src = r_s1_valid & r_s1_rw & (r_s1_rd != C_X0);
    assign w_s2_src = r_s2_valid & r_s2_rw & (r_s2_rd != C_X0);
    assign w_s3_src = r_s3_valid & r_s3_rw & (r_s3_rd != C_X0);

    // An operand is eligible when the ID instruction is real and reads a non-x0 source
    assign w_a_use = id_valid_i & id_use_rs1_i & (id_rs1_i != C_X0);
    assign w_b_use = id_valid_i & id_use_rs2_i & (id_rs2_i != C_X0);

    assign w_a_m1 = w_a_use & w_s1_src & (id_rs1_i == r_s1_rd);
    assign w_a_m2 = w_a_use & w_s2_src & (id_rs1_i == r_s2_rd);
    assign w_a_m3 = w_a_use & w_s3_src & (id_rs1_i == r_s3_rd);
    assign w_b_m1 = w_b_use & w_s1_src & (id_rs2_i == r_s1_rd);
    assign w_b_m2 = w_b_use & w_s2_src & (id_rs2_i == r_s2_rd);
    assign w_b_m3 = w_b_use & w_s3_src & (id_rs2_i == r_s3_rd);

    // Nearest producer wins for each operand independently
    always_comb begin
        w_sel_a = C_SEL_RF;
        if (w_a_m1)      w_sel_a = C_SEL_MEM;
        else if (w_a_m2) w_sel_a = C_SEL_WB;
        else if (w_a_m3) w_sel_a = C_SEL_RET;

        w_sel_b = C_SEL_RF;
        if (w_b_m1)      w_sel_b = C_SEL_MEM;
        else if (w_b_m2) w_sel_b = C_SEL_WB;
        else if (w_b_m3) w_sel_b = C_SEL_RET;
    end

    // A load one stage ahead cannot supply its data in time: insert one bubble
    assign w_stall = id_valid_i & ~flush_i & ~hold_i & w_s1_src & r_s1_mr
                   & (w_a_m1 | w_b_m1);

    // Shadow pipeline advance and select registration
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_valid  <= 1'b0;
            r_s1_rd     <= C_X0;
            r_s1_rw     <= 1'b0;
            r_s1_mr     <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_rd     <= C_X0;
            r_s2_rw     <= 1'b0;
            r_s2_mr     <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_s3_rd     <= C_X0;
            r_s3_rw     <= 1'b0;
            r_s3_mr     <= 1'b0;
            r_fwd_a_sel <= C_SEL_RF;
            r_fwd_b_sel <= C_SEL_RF;
        end else if (!hold_i) begin
            r_s2_valid <= r_s1_valid;
            r_s2_rd    <= r_s1_rd;
            r_s2_rw    <= r_s1_rw;
            r_s2_mr    <= r_s1_mr;
            r_s3_valid <= r_s2_valid;
            r_s3_rd    <= r_s2_rd;
            r_s3_rw    <= r_s2_rw;
            r_s3_mr    <= r_s2_mr;
            if (flush_i || w_stall || !id_valid_i) begin
                // Bubble enters EX; it reads nothing, so selects go to the register file
                r_s1_valid  <= 1'b0;
                r_s1_rd     <= C_X0;
                r_s1_rw     <= 1'b0;
                r_s1_mr     <= 1'b0;
                r_fwd_a_sel <= C_SEL_RF;
                r_fwd_b_sel <= C_SEL_RF;
            end else begin
                r_s1_valid  <= 1'b1;
                r_s1_rd     <= id_rd_i;
                r_s1_rw     <= id_reg_write_i;
                r_s1_mr     <= id_mem_read_i;
                r_fwd_a_sel <= w_sel_a;
                r_fwd_b_sel <= w_sel_b;
            end
        end
    end

    assign fwd_a_sel_o = r_fwd_a_sel;
    assign fwd_b_sel_o = r_fwd_b_sel;
    assign stall_o     = w_stall;

endmodule
`default_nettype wire

// File: doc/fwd_sel_gen.md
# fwd_sel_gen

Forwarding-select generator for the 5-stage RV32I pipeline. Tracks the destination register, write-enable and load flag of the instructions in EX, MEM and WB in its own shadow pipeline. From these it produces the registered 2-bit operand selects that drive the EX-stage register-data multiplexers, and raises a load-use stall when forwarding cannot resolve a hazard. It sits beside the ID/EX pipeline register and is the control end of the operand-select interface.

## Interface
- No parameters.
- clk_i  input  1  pipeline clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- id_valid_i  input  1  ID holds a real instruction
- id_rs1_i, id_rs2_i  input  5 each  ID source registers
- id_use_rs1_i, id_use_rs2_i  input  1 each  instruction actually reads rs1/rs2
- id_rd_i  input  5  ID destination register
- id_reg_write_i  input  1  ID instruction writes rd
- id_mem_read_i  input  1  ID instruction is a load
- flush_i  input  1  squash ID instruction (branch taken/jump)
- hold_i  input  1  global freeze (memory wait); all state holds
- fwd_a_sel_o, fwd_b_sel_o  output  2 each  registered operand selects for the EX instruction: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB writeback data, 3 = WB-retired latch
- stall_o  output  1  load-use stall; combinational

## Operation
- Shadow stages S1 (EX), S2 (MEM), S3 (WB). Each holds valid, rd[4:0], reg_write, mem_read.
- A stage is a forwarding source only when valid=1, reg_write=1 and rd≠0.
- Hazard match per operand: use_rsX=1, rsX≠0, rsX == stage rd, stage is a source.
- Select computed in ID, registered into EX. Priority is nearest first:
  - S1 match -> 1. S1 will be in MEM when the current ID instruction reaches EX.
  - else S2 match -> 2.
  - else S3 match -> 3.
  - else 0.
- stall_o = id_valid_i & ~flush_i & ~hold_i & S1 is a source & S1.mem_read & (rs1 match S1 | rs2 match S1).
- Per-edge update, evaluated in priority order:
  - hold_i=1: every register holds; fwd selects hold.
  - flush_i=1 (overrides stall): S1 <= bubble; S2<=S1; S3<=S2; fwd selects <= 0.
  - stall_o=1: S1 <= bubble; S2<=S1; S3<=S2; fwd selects <= 0. The external ID stage holds, so the same instruction is re-evaluated next cycle.
  - Otherwise: S1 <= {id_valid_i, id_rd_i, id_reg_write_i, id_mem_read_i}; S2<=S1; S3<=S2; fwd selects <= computed values.
  - A bubble is valid=0, rd=0, reg_write=0, mem_read=0.
- Invalid ID instruction (id_valid_i=0): S1 receives a bubble and selects load 0.
- No arithmetic beyond 5-bit equality compares. x0 is never forwarded.

## Timing
- Reset (asynchronous, immediate): S1–S3 all bubbles; fwd_a_sel_o=fwd_b_sel_o=0; stall_o=0.
- Reset asserted mid-operation discards all tracked hazards. On the first edge after release, selects load from the current ID inputs.
- Select latency: 1 cycle. Values computed while the instruction is in ID appear on fwd_*_sel_o during its EX cycle.
- Load-use: exactly one stall cycle per hazard.
  - Cycle n: stall_o=1.
  - Cycle n+1: the load is in S2, stall_o=0, and the dependent operand's select loads 2. It reads the load data at the MEM/WB writeback point.
- stall_o is valid within the same cycle as the ID inputs. It has no registered path.
- Simultaneous cases:
  - hold_i with flush_i or stall: hold wins and nothing changes.
  - flush_i with stall: flush wins, stall_o=0, S1 gets a bubble.
- Both operands are evaluated independently. They may select different sources in the same cycle.

## Test plan
- Reset: assert rst_i asynchronously mid-stream after loading S1 with rd=5 -> selects 0 immediately, stall_o=0. Then an ID read of x5 after release -> select 0.
- Back-to-back ALU dependency: `add x5,..` then `sub x6,x5,x5` -> in sub's EX cycle, fwd_a_sel_o=1 and fwd_b_sel_o=1.
- Distance 2 and 3: producer rd=7, consumer two later -> select 2. Consumer three later -> select 3. Four later -> select 0. Producer repeated at distance 1 and 2 -> select 1 (nearest wins).
- Load-use: `lw x8` then `add x9,x8,x1` -> stall_o=1 for one cycle, bubble in EX (selects 0). Next cycle stall_o=0, then fwd_a_sel_o=2 and fwd_b_sel_o=0.
- x0 and non-use: producer rd=0 with reg_write=1, consumer rs1=0 -> select 0. Consumer with id_use_rs2_i=0 and rs2 matching -> select 0, no stall.
- Flush/hold: flush_i during a load-use hazard -> stall_o=0 and S1 bubble. hold_i=1 for 3 cycles -> outputs and S1–S3 unchanged, then the pipeline resumes with the same selects.
